// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: accepts one byte per ok strobe and shifts it out LSB first on txd.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_transmitter #(
    parameter int unsigned WAIT_CYCLES = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       ok,
    output logic       busy,
    output logic       txd
);

    localparam int unsigned CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_TX_PARITY_EN
        , S_PARITY
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                txd_q, txd_d;
    logic                busy_q, busy_d;
    logic                bit_done_c;
`ifdef UART_TX_PARITY_EN
    logic                parity_q, parity_d;
`endif

    assign busy       = busy_q;
    assign txd        = txd_q;
    assign bit_done_c = (cnt_q == CNT_LAST);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state and output logic; txd/busy are computed one edge ahead so they leave registered
    always_comb begin
        state_d  = state_q;
        cnt_d    = bit_done_c ? '0 : cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        busy_d   = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (ok && !busy_q) begin
                    shift_d  = data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^data;
`endif
                    busy_d   = 1'b1;
                    txd_d    = 1'b0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (bit_done_c) begin
                    idx_d   = '0;
                    txd_d   = shift_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done_c) begin
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = parity_q;
                        state_d = S_PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done_c) begin
                    txd_d   = 1'b1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_done_c) begin
                    txd_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with WAIT_CYCLES=4; frame length follows UART_TX_PARITY_EN.
module tb_uart_transmitter;

    localparam int W = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FLEN = 11;
`else
    localparam int FLEN = 10;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] data;
    logic       ok;
    logic       busy;
    logic       txd;

    int tests_run;
    int tests_failed;

    uart_transmitter #(.WAIT_CYCLES(W)) dut (
        .clk   (clk),
        .reset (reset),
        .data  (data),
        .ok    (ok),
        .busy  (busy),
        .txd   (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
        end
    endtask

    // Drive a one-cycle ok strobe; returns sampled in the cycle that starts at the accepting edge
    task automatic start_frame(input logic [7:0] d);
        data = d;
        ok   = 1'b1;
        tick();
        ok   = 1'b0;
        data = ~d;
    endtask

    // Check every cycle of the frame, optionally injecting an ok strobe at cycle inj_k
    task automatic check_frame(input string tag, input logic [7:0] d, input int inj_k, input logic [7:0] inj_d);
        logic [FLEN-1:0] bits;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        bits[9] = ^d;
`endif
        bits[FLEN-1] = 1'b1;
        for (int k = 0; k < FLEN * W; k++) begin
            chk({tag, "_txd"}, k, txd, bits[k / W]);
            chk({tag, "_busy"}, k, busy, 1'b1);
            if (k == inj_k) begin
                ok   = 1'b1;
                data = inj_d;
            end else if (k == inj_k + 1) begin
                ok   = 1'b0;
            end
            tick();
        end
        chk({tag, "_end_busy"}, FLEN * W, busy, 1'b0);
        chk({tag, "_end_txd"}, FLEN * W, txd, 1'b1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b1;
        ok    = 1'b1;
        data  = 8'hAA;

        // Reset held with ok asserted: line idle, no frame
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_txd", i, txd, 1'b1);
            chk("rst_busy", i, busy, 1'b0);
        end
        reset = 1'b0;
        ok    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_txd", i, txd, 1'b1);
            chk("idle_busy", i, busy, 1'b0);
        end

        // Single byte A5
        start_frame(8'hA5);
        check_frame("a5", 8'hA5, -10, 8'h00);
        tick();
        chk("a5_post_txd", 0, txd, 1'b1);
        chk("a5_post_busy", 0, busy, 1'b0);

        // Back-to-back: 00 then FF at first cycle busy is low
        start_frame(8'h00);
        check_frame("b00", 8'h00, -10, 8'h00);
        start_frame(8'hFF);
        check_frame("bff", 8'hFF, -10, 8'h00);

        // Request while busy is ignored
        start_frame(8'h3C);
        check_frame("b3c", 8'h3C, 13, 8'h81);
        for (int i = 0; i < 2 * W; i++) begin
            chk("ign_txd", i, txd, 1'b1);
            chk("ign_busy", i, busy, 1'b0);
            tick();
        end

        // Reset mid-frame at E+17
        start_frame(8'h55);
        for (int k = 0; k < 16; k++) tick();
        chk("mid_txd_pre", 16, txd, 1'b0);
        chk("mid_busy_pre", 16, busy, 1'b1);
        reset = 1'b1;
        tick();
        chk("mid_txd_rst", 17, txd, 1'b1);
        chk("mid_busy_rst", 17, busy, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            tick();
            chk("mid_idle_txd", i, txd, 1'b1);
            chk("mid_idle_busy", i, busy, 1'b0);
        end
        start_frame(8'h0F);
        check_frame("b0f", 8'h0F, -10, 8'h00);

        // Parity odd/even weight data bytes
        tick();
        start_frame(8'h07);
        check_frame("b07", 8'h07, -10, 8'h00);
        tick();
        start_frame(8'h03);
        check_frame("b03", 8'h03, -10, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmitter for the UART path: accepts one byte per `ok` pulse from the UART controller's transmit-buffer side and shifts it out on `txd` as an asynchronous 8N1 frame at a fixed bit period. It is the consumer end of the controller's `trans_data` / `trans_ok` / `trans_busy` / `trans_reset` interface and drives the board TX pin directly.

## Interface

- `WAIT_CYCLES`, default 868: clock cycles per bit (100 MHz / 115200). Legal range is ≥ 2.
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high; driven from the controller's `trans_reset`.
- `data`  in  8  byte to send; sampled only on the accepting edge.
- `ok`  in  1  one-cycle request strobe; accepted when `busy` is 0.
- `busy`  out  1  registered; high from the edge after acceptance through the end of the stop bit.
- `txd`  out  1  registered serial line; idle level is 1.

## Operation

- Reset values: `txd`=1, `busy`=0, state IDLE, baud counter 0, bit index 0, shift register 0.
- States:
  - IDLE: `txd`=1.
  - START: `txd`=0.
  - DATA: bits 0..7, LSB first.
  - (PARITY): only with the parity macro.
  - STOP: `txd`=1.
- Acceptance happens on an edge in IDLE where `ok`=1 and `busy`=0.
  - On that edge: latch `data`, set `busy`<=1 and `txd`<=0, clear the baud counter, go to START.
- `ok` while `busy`=1 is ignored. `data` changes after acceptance have no effect on the frame in flight.
- Baud counter behaviour:
  - It counts 0..WAIT_CYCLES-1 inside each bit.
  - On reaching WAIT_CYCLES-1 it wraps to 0 and the FSM advances.
  - Counter width is `$clog2(WAIT_CYCLES)`.
- Bit sequencing:
  - START → DATA (bit index 0).
  - In DATA, the index increments each bit and the shift register shifts right, so `txd` = shift[0].
  - After index 7, go to STOP (or to PARITY, then STOP).
- End of frame: on the last cycle of STOP, go to IDLE with `busy`<=0; `txd` stays 1.
- Reset mid-frame: on the next edge `txd`=1, `busy`=0 and the FSM is in IDLE. The truncated frame is abandoned and not resumed.

## Timing

- Let E be the accepting edge and W = WAIT_CYCLES.
- Start bit: `txd`=0 during cycles [E, E+W).
- Data bit i: on `txd` during [E+(i+1)W, E+(i+2)W).
- Stop bit: 1 during [E+9W, E+10W).
- At edge E+10W, `busy` falls. The earliest next acceptance is edge E+10W+1, which guarantees ≥ 1 idle cycle between frames.
- `busy` is high in the cycle after E, so a controller that raises `ok` for one cycle and then checks `busy` never issues a second request during the frame.
- Every bit is exactly W cycles, with no drift across the frame.
- Latency from `ok` sample to the falling start edge is 0 cycles; `txd` changes at edge E.

## Configuration

- `UART_TX_PARITY_EN`:
  - Defined: an even-parity bit (XOR of the 8 latched data bits) is sent after bit 7 during [E+9W, E+10W). The stop bit moves to [E+10W, E+11W) and `busy` falls at edge E+11W.
  - Undefined: plain 8N1 as above, with no parity state in the RTL.

## Test plan

- Reset check: assert `reset` for 3 cycles with `ok`=1 → `txd`=1 and `busy`=0 throughout, and no frame starts.
- Single byte, W=4: `ok` pulse with `data`=8'hA5 → `txd` reads 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles. `busy` is high for cycles 1..40 after E and low at E+40.
- Back-to-back bytes, W=4: send 8'h00, then `ok` with 8'hFF at the first cycle `busy`=0 → two complete frames, a single idle cycle between them, correct bit values.
- Request while busy: with W=4, sending 8'h3C, pulse `ok` with 8'h81 at E+13 → the 8'h81 request is ignored; only 8'h3C appears, and `busy` falls at E+40.
- Reset mid-frame: assert `reset` at E+17 while sending 8'h55 → `txd`=1 and `busy`=0 after that edge. A subsequent `ok` with 8'h0F sends a clean frame.
- Parity build, `UART_TX_PARITY_EN`, W=4: send 8'h07 → parity bit 1 during [E+36, E+40), stop bit during [E+40, E+44), `busy` falls at E+44. Sending 8'h03 gives parity bit 0.
